// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared JPEG pipeline constants, coefficient type and zigzag table
//
// Purpose: constants shared by the zigzag reorder buffer and its bank sub-module.
//   COEF_W_DEFAULT : default quantized coefficient width (two's complement)
//   BLOCK_N        : coefficients per 8x8 block
//   coef_t         : coefficient type at the default width
//   ZZ             : zigzag position -> raster index lookup
// Optional feature macro used by the buffer: ZIGZAG_LAST_EN.
package jpeg_pkg;

    localparam int COEF_W_DEFAULT = 11;
    localparam int BLOCK_N        = 64;

    typedef logic [COEF_W_DEFAULT-1:0] coef_t;

    // Entry k is the raster index of the k-th coefficient in zigzag order.
    localparam logic [5:0] ZZ [BLOCK_N] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] zz_addr(input logic [5:0] idx);
        return ZZ[idx];
    endfunction

endpackage

// File: rtl/zigzag_buffer_if.sv
// rtl/zigzag_buffer_if.sv - coefficient stream interface for the zigzag reorder buffer
//
// Purpose: bundles the upstream (raster) and downstream (zigzag) handshakes.
//   ena_in   : upstream coefficient valid (every high cycle is a transfer)
//   rdy_out  : buffer can accept a coefficient this cycle
//   in       : raster-order coefficient
//   ena_out  : output coefficient valid (every high cycle is a transfer)
//   rdy_in   : downstream ready
//   out      : zigzag-order coefficient
//   last_out : end-of-block marker, present only with ZIGZAG_LAST_EN
// Modports: master = pipeline side driving the buffer, slave = the buffer.
interface zigzag_buffer_if
    import jpeg_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEFAULT
);

    logic              ena_in;
    logic              rdy_out;
    logic [COEF_W-1:0] in;
    logic              ena_out;
    logic              rdy_in;
    logic [COEF_W-1:0] out;
`ifdef ZIGZAG_LAST_EN
    logic              last_out;

    modport master (
        output ena_in, in, rdy_in,
        input  rdy_out, ena_out, out, last_out
    );

    modport slave (
        input  ena_in, in, rdy_in,
        output rdy_out, ena_out, out, last_out
    );
`else
    modport master (
        output ena_in, in, rdy_in,
        input  rdy_out, ena_out, out
    );

    modport slave (
        input  ena_in, in, rdy_in,
        output rdy_out, ena_out, out
    );
`endif

endinterface

// File: rtl/zigzag_bank.sv
// rtl/zigzag_bank.sv - one 64 x COEF_W coefficient bank, sync write / async read
//
// Purpose: storage for one 8x8 block; contents are never reset.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address (raster index)
//   wdata_i : write data
//   raddr_i : read address (raster index from the zigzag lookup)
//   rdata_o : combinational read data
module zigzag_bank
    import jpeg_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEFAULT
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [5:0]        waddr_i,
    input  logic [COEF_W-1:0] wdata_i,
    input  logic [5:0]        raddr_i,
    output logic [COEF_W-1:0] rdata_o
);

    logic [COEF_W-1:0] mem_q [BLOCK_N];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/zigzag_buffer.sv
// rtl/zigzag_buffer.sv - double-banked raster-to-zigzag reorder buffer for 8x8 blocks
//
// Purpose: accepts 64 raster-order coefficients per block and re-emits them in
// JPEG zigzag order; one bank fills while the other drains.
//   clk : clock
//   rst : synchronous active-high reset (flags, indices, bank selects)
//   bus : zigzag_buffer_if.slave (ena_in/rdy_out/in upstream,
//         ena_out/rdy_in/out downstream, last_out with ZIGZAG_LAST_EN)
// Optional feature macro: ZIGZAG_LAST_EN adds last_out = ena_out && rd_idx==63.
module zigzag_buffer
    import jpeg_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    zigzag_buffer_if.slave bus
);

    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic [5:0] wr_idx_q, wr_idx_d;
    logic       rd_bank_q, rd_bank_d;
    logic [5:0] rd_idx_q, rd_idx_d;

    logic       rdy_out;
    logic       ena_out;
    logic       wr_fire;
    logic       wr_last;
    logic       rd_last;
    logic [5:0] rd_addr;

    logic [COEF_W-1:0] rd_data [2];

    // The handshake is ena-only: the producer promises to assert ena only when
    // rdy is high. Gating the write with rdy_out makes a violating write a no-op.
    assign rdy_out = !full_q[wr_bank_q] && !rst;
    assign ena_out = bus.rdy_in && full_q[rd_bank_q] && !rst;
    assign wr_fire = bus.ena_in && rdy_out;
    assign wr_last = wr_fire && (wr_idx_q == 6'd63);
    assign rd_last = ena_out && (rd_idx_q == 6'd63);
    assign rd_addr = zz_addr(rd_idx_q);

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;

        if (wr_fire) begin
            wr_idx_d = wr_idx_q + 6'd1;
        end
        if (ena_out) begin
            rd_idx_d = rd_idx_q + 6'd1;
        end

        // A completing write targets an empty bank and a completing read a full
        // one, so the two flag updates never hit the same bank.
        if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            wr_idx_q  <= 6'd0;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= 6'd0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        zigzag_bank #(
            .COEF_W (COEF_W)
        ) u_bank (
            .clk     (clk),
            .we_i    (wr_fire && (wr_bank_q == 1'(b))),
            .waddr_i (wr_idx_q),
            .wdata_i (bus.in),
            .raddr_i (rd_addr),
            .rdata_o (rd_data[b])
        );
    end

    assign bus.rdy_out = rdy_out;
    assign bus.ena_out = ena_out;
    assign bus.out     = rd_data[rd_bank_q];
`ifdef ZIGZAG_LAST_EN
    assign bus.last_out = ena_out && (rd_idx_q == 6'd63);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.ena_in && !rdy_out));
        end
    end

endmodule
